// File: rtl/idt_cfg_if.sv
// Request/ack bundle between the SoC and the IDT synthesizer programming controller.
interface idt_cfg_if;
  localparam int unsigned CFG_W = 24;

  logic             cfg_req;
  logic [CFG_W-1:0] cfg_word;
  logic             cfg_ack;
  logic             cfg_busy;
  logic             cfg_done;
  logic             clk_valid;

  modport master (
    output cfg_req, cfg_word,
    input  cfg_ack, cfg_busy, cfg_done, clk_valid
  );

  modport slave (
    input  cfg_req, cfg_word,
    output cfg_ack, cfg_busy, cfg_done, clk_valid
  );
endinterface

// File: rtl/idt_cfg_ctrl.sv
// Serial programming sequencer for the IDT clock synthesizer driving idt_clk1.
// Shifts a 24-bit word MSB first, pulses the load strobe, then waits for relock
// before raising clk_valid. All outputs are registered from next-state decode.
module idt_cfg_ctrl #(
  parameter int unsigned SCLK_DIV      = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 65536,
  parameter bit          AUTO_CFG      = 1'b1,
  parameter logic [23:0] DEFAULT_CFG   = 24'h000000
) (
  input  logic   osc_clk,
  input  logic   osc_reset_,
  idt_cfg_if.slave bus,
  output logic   idt_sclk,
  output logic   idt_data,
  output logic   idt_strobe
);

  localparam int unsigned WORD_W = 24;
  localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(WORD_W);
  localparam int unsigned STR_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TMR_W  = (STR_W > SET_W) ? STR_W : SET_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] STR_LAST = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, STROBE_GAP, STROBE, SETTLE
  } state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   word, word_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [DIV_W-1:0]    div_cnt, div_n;
  logic [TMR_W-1:0]    tmr, tmr_n;
  logic                auto_pending, auto_n;
  logic                start_c;

  logic ack_q, busy_q, done_q, valid_q;
  logic ack_n, busy_n, done_n, valid_n;
  logic sclk_n, data_n, strobe_n;

  assign bus.cfg_ack   = ack_q;
  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_done  = done_q;
  assign bus.clk_valid = valid_q;

  // State, counters and registered outputs.
  always_ff @(posedge osc_clk or negedge osc_reset_) begin
    if (!osc_reset_) begin
      state        <= IDLE;
      word         <= '0;
      idx          <= '0;
      div_cnt      <= '0;
      tmr          <= '0;
      auto_pending <= AUTO_CFG;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      idt_sclk     <= 1'b0;
      idt_data     <= 1'b0;
      idt_strobe   <= 1'b0;
    end else begin
      state        <= state_n;
      word         <= word_n;
      idx          <= idx_n;
      div_cnt      <= div_n;
      tmr          <= tmr_n;
      auto_pending <= auto_n;
      ack_q        <= ack_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      valid_q      <= valid_n;
      idt_sclk     <= sclk_n;
      idt_data     <= data_n;
      idt_strobe   <= strobe_n;
    end
  end

  // Next-state sequencing; outputs decoded from the next state so they register in phase.
  always_comb begin
    state_n = state;
    word_n  = word;
    idx_n   = idx;
    div_n   = div_cnt;
    tmr_n   = tmr;
    auto_n  = auto_pending;
    ack_n   = 1'b0;
    valid_n = valid_q;
    start_c = 1'b0;

    case (state)
      IDLE: begin
        if (auto_pending) begin
          word_n  = DEFAULT_CFG;
          auto_n  = 1'b0;
          start_c = 1'b1;
        end else if (bus.cfg_req) begin
          word_n  = bus.cfg_word;
          ack_n   = 1'b1;
          start_c = 1'b1;
        end
        if (start_c) begin
          state_n = SHIFT_LO;
          idx_n   = IDX_W'(WORD_W - 1);
          div_n   = '0;
          valid_n = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (idx == '0) begin
            state_n = STROBE_GAP;
          end else begin
            idx_n   = idx - IDX_W'(1);
            state_n = SHIFT_LO;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      STROBE_GAP: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          tmr_n   = '0;
          state_n = STROBE;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      STROBE: begin
        if (tmr == STR_LAST) begin
          tmr_n   = '0;
          state_n = SETTLE;
        end else begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr == SET_LAST) begin
          tmr_n   = '0;
          valid_n = 1'b1;
          state_n = IDLE;
        end else if (tmr != '1) begin
          tmr_n = tmr + TMR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    sclk_n   = (state_n == SHIFT_HI);
    data_n   = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) ? word_n[idx_n] : 1'b0;
    strobe_n = (state_n == STROBE);
    busy_n   = (state_n != IDLE);
    done_n   = (state_n == SETTLE) && (tmr_n == SET_LAST);
  end

endmodule
